pipeline_id_tracker: RTL and testbench
======================================

// Module: pipeline_id_tracker
// PURPOSE
// Assigns a sequence ID to every fetched instruction and carries ID + valid tag
// through the IF, ID, EX, MEM and WB stage slots, mirroring CPU stall/flush.
// Sits directly upstream of the pipeline debug-message collector: it supplies the
// per-stage IDs/valids used to index message storage and the retire strobe that
// triggers the per-instruction print. Also counts retire/bubble/flush events and
// flags out-of-order retirement.
// PARAMETERS
// ID_DEPTH  72  number of distinct IDs; IDs wrap ID_DEPTH-1 -> 0 (>=2)
// CNT_W     32  width of event counters (saturate, no wrap)
// PORTS
// clk           in   1      clock, all state updates on rising edge
// rst_n         in   1      asynchronous active-low reset
// pc_stall      in   1      PC hold (hazard)
// if_id_stall   in   1      IF/ID hold (hazard)
// if_flush      in   1      kill instruction entering ID
// id_flush      in   1      kill instruction entering EX
// halt          in   1      stop issuing new IDs (drain)
// f_id,d_id,x_id,m_id,w_id  out IW  stage IDs, IW=$clog2(ID_DEPTH)
// f_vld,d_vld,x_vld,m_vld,w_vld out 1 stage valid tags
// retire_vld    out  1      = w_vld; one pulse per completed instruction
// retire_id     out  IW     = w_id
// retired_cnt   out  CNT_W  instructions retired
// bubble_cnt    out  CNT_W  stall cycles (bubbles inserted into EX)
// flush_cnt     out  CNT_W  valid instructions killed by if_flush/id_flush
// drained       out  1      all five valids low
// seq_err       out  1      sticky: retire_id != expected next ID
// BEHAVIOUR
// - Reset (async assert, sync release): f_id=0, f_vld=1; all other IDs 0, valids 0;
//   counters 0; seq_err 0; expected-retire ID 0. drained=0 (f_vld=1).
// - stall = pc_stall | if_id_stall. Per cycle, priority top-down:
//   - stall: F and D hold id/vld; X<=bubble (x_vld=0, x_id holds); M<=X; W<=M;
//     bubble_cnt++. If if_flush also high: d_vld<=0 (flush wins over hold), F holds.
//   - no stall: f_id<=(f_id+1) mod ID_DEPTH, f_vld<=~halt; D<=F with
//     d_vld<=f_vld&~if_flush; X<=D with x_vld<=d_vld&~id_flush; M<=X; W<=M.
//   - ID increments only when F advances with f_vld=1; halted F holds f_id.
// - halt sampled only when F advances; once f_vld=0 it stays 0 until reset.
// - flush_cnt += (if_flush & killed-slot valid) + (id_flush & d_vld & ~stall);
//   both in same cycle add 2.
// - Latency: an ID issued in F with no stall/flush reaches W 4 cycles later.
// - Retire check: on w_vld, if w_id != exp_id set seq_err (sticky to reset);
//   exp_id <= (w_id+1) mod ID_DEPTH (resynchronise after error). retired_cnt++.
// - Counters saturate at all-ones. Wrap of IDs at ID_DEPTH-1 is not an error.
// - Mid-operation reset: all state cleared immediately, no retire pulse emitted.
// - drained is combinational NOR of the five valids.
// TESTING
// - Release reset, 10 idle cycles -> retire_vld first high cycle 4, retire_id 0,1,2..;
//   retired_cnt=6 after cycle 9; seq_err=0.
// - if_id_stall high 2 cycles at cycle 3 -> d_id held, two x_vld=0 bubbles,
//   bubble_cnt=2, retire IDs stay contiguous, retire gap of 2 cycles.
// - if_flush at cycle 5 -> ID 4 never retires, flush_cnt=1, seq_err=1 (gap 3->5).
// - if_flush+id_flush same cycle -> two IDs killed, flush_cnt=2.
// - Run 80 unstalled cycles, ID_DEPTH=72 -> retire_id 71 followed by 0, seq_err=0.
// - halt at cycle 8 -> pipeline empties, drained=1 by cycle 13; rst_n low mid-run
//   -> all valids/counters 0 asynchronously, f_vld=1 after release.

Source files
------------

// File: rtl/pipeline_id_tracker.sv
// -----------------------------------------------------------------------------
// pipeline_id_tracker
//
// Purpose:
//   Gives every fetched instruction a sequence ID and carries the ID plus a
//   valid tag through five stage slots (IF, ID, EX, MEM, WB). The slots follow
//   the CPU's stall and flush behaviour, so a downstream debug-message
//   collector can index its storage by stage ID. A retire strobe is raised
//   for each instruction that leaves WB. The block also counts retires,
//   bubbles and flush kills, and flags out-of-order retirement.
//
// Parameters:
//   ID_DEPTH  number of distinct IDs; IDs wrap ID_DEPTH-1 -> 0 (>= 2)
//   CNT_W     width of the saturating event counters
//
// Ports:
//   clk_i            clock, rising-edge
//   rst_ni           asynchronous active-low reset
//   pc_stall_i       PC hold (hazard)
//   if_id_stall_i    IF/ID hold (hazard)
//   if_flush_i       kill the instruction entering ID
//   id_flush_i       kill the instruction entering EX
//   halt_i           stop issuing new IDs; the pipeline drains
//   {f,d,x,m,w}_id_o   stage IDs
//   {f,d,x,m,w}_vld_o  stage valid tags
//   retire_vld_o     one pulse per completed instruction (= w_vld_o)
//   retire_id_o      ID of the retiring instruction (= w_id_o)
//   retired_cnt_o    instructions retired
//   bubble_cnt_o     stall cycles (bubbles inserted into EX)
//   flush_cnt_o      valid instructions killed by if_flush_i / id_flush_i
//   drained_o        all five valid tags low
//   seq_err_o        sticky: a retired ID differed from the expected next ID
// -----------------------------------------------------------------------------
module pipeline_id_tracker #(
  parameter  int ID_DEPTH = 72,
  parameter  int CNT_W    = 32,
  localparam int IW       = $clog2(ID_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pc_stall_i,
  input  logic             if_id_stall_i,
  input  logic             if_flush_i,
  input  logic             id_flush_i,
  input  logic             halt_i,
  output logic [IW-1:0]    f_id_o,
  output logic [IW-1:0]    d_id_o,
  output logic [IW-1:0]    x_id_o,
  output logic [IW-1:0]    m_id_o,
  output logic [IW-1:0]    w_id_o,
  output logic             f_vld_o,
  output logic             d_vld_o,
  output logic             x_vld_o,
  output logic             m_vld_o,
  output logic             w_vld_o,
  output logic             retire_vld_o,
  output logic [IW-1:0]    retire_id_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             drained_o,
  output logic             seq_err_o
);

  localparam logic [IW-1:0]    ID_LAST = IW'(ID_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Modulo-ID_DEPTH increment. ID_DEPTH need not be a power of two, so the
  // wrap is explicit rather than relying on IW-bit overflow.
  function automatic logic [IW-1:0] incId(input logic [IW-1:0] id);
    return (id == ID_LAST) ? '0 : id + IW'(1);
  endfunction

  // Saturating add of a small increment (0..2) to an event counter.
  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt,
                                              input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Stage slot registers
  logic [IW-1:0] fId_q, fId_d;
  logic [IW-1:0] dId_q, dId_d;
  logic [IW-1:0] xId_q, xId_d;
  logic [IW-1:0] mId_q, mId_d;
  logic [IW-1:0] wId_q, wId_d;
  logic          fVld_q, fVld_d;
  logic          dVld_q, dVld_d;
  logic          xVld_q, xVld_d;
  logic          mVld_q, mVld_d;
  logic          wVld_q, wVld_d;

  // Event counters and retire-order checker
  logic [CNT_W-1:0] retiredCnt_q, retiredCnt_d;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic [IW-1:0]    expId_q, expId_d;
  logic             seqErr_q, seqErr_d;

  logic       stall;
  logic       ifKill;
  logic       idKill;
  logic [1:0] flushInc;

  assign stall = pc_stall_i | if_id_stall_i;

  // During a stall if_flush_i hits the held instruction in D. Otherwise it
  // hits the instruction moving from F into D. id_flush_i only matters when D
  // actually advances into EX; during a stall EX receives a bubble anyway.
  assign ifKill   = if_flush_i & (stall ? dVld_q : fVld_q);
  assign idKill   = id_flush_i & dVld_q & ~stall;
  assign flushInc = {1'b0, ifKill} + {1'b0, idKill};

  // Stage movement. F and D hold on a stall while EX takes a bubble. MEM and
  // WB always advance, so older instructions keep draining past the hazard.
  // F's ID advances only when a valid F moves on. Once halt_i clears f_vld it
  // never sets again, which freezes f_id at the first unissued ID.
  always_comb begin
    fId_d  = fId_q;
    fVld_d = fVld_q;
    dId_d  = dId_q;
    dVld_d = dVld_q;
    xId_d  = xId_q;
    xVld_d = xVld_q;
    mId_d  = xId_q;
    mVld_d = xVld_q;
    wId_d  = mId_q;
    wVld_d = mVld_q;

    if (stall) begin
      dVld_d = dVld_q & ~if_flush_i;
      xVld_d = 1'b0;
    end else begin
      fVld_d = fVld_q & ~halt_i;
      if (fVld_q) begin
        fId_d = incId(fId_q);
      end
      dId_d  = fId_q;
      dVld_d = fVld_q & ~if_flush_i;
      xId_d  = dId_q;
      xVld_d = dVld_q & ~id_flush_i;
    end
  end

  // Counters and retire-order check. After a mismatch the expected ID is
  // re-anchored on the ID that actually retired, so one gap is reported once
  // and not on every later retire.
  always_comb begin
    retiredCnt_d = retiredCnt_q;
    bubbleCnt_d  = bubbleCnt_q;
    flushCnt_d   = satAdd(flushCnt_q, flushInc);
    expId_d      = expId_q;
    seqErr_d     = seqErr_q;

    if (stall) begin
      bubbleCnt_d = satAdd(bubbleCnt_q, 2'd1);
    end

    if (wVld_q) begin
      retiredCnt_d = satAdd(retiredCnt_q, 2'd1);
      expId_d      = incId(wId_q);
      if (wId_q != expId_q) begin
        seqErr_d = 1'b1;
      end
    end
  end

  // Reset leaves a valid ID 0 sitting in F so fetch starts on the first
  // edge after release. Every downstream slot is empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fId_q        <= '0;
      fVld_q       <= 1'b1;
      dId_q        <= '0;
      dVld_q       <= 1'b0;
      xId_q        <= '0;
      xVld_q       <= 1'b0;
      mId_q        <= '0;
      mVld_q       <= 1'b0;
      wId_q        <= '0;
      wVld_q       <= 1'b0;
      retiredCnt_q <= '0;
      bubbleCnt_q  <= '0;
      flushCnt_q   <= '0;
      expId_q      <= '0;
      seqErr_q     <= 1'b0;
    end else begin
      fId_q        <= fId_d;
      fVld_q       <= fVld_d;
      dId_q        <= dId_d;
      dVld_q       <= dVld_d;
      xId_q        <= xId_d;
      xVld_q       <= xVld_d;
      mId_q        <= mId_d;
      mVld_q       <= mVld_d;
      wId_q        <= wId_d;
      wVld_q       <= wVld_d;
      retiredCnt_q <= retiredCnt_d;
      bubbleCnt_q  <= bubbleCnt_d;
      flushCnt_q   <= flushCnt_d;
      expId_q      <= expId_d;
      seqErr_q     <= seqErr_d;
    end
  end

  assign f_id_o        = fId_q;
  assign d_id_o        = dId_q;
  assign x_id_o        = xId_q;
  assign m_id_o        = mId_q;
  assign w_id_o        = wId_q;
  assign f_vld_o       = fVld_q;
  assign d_vld_o       = dVld_q;
  assign x_vld_o       = xVld_q;
  assign m_vld_o       = mVld_q;
  assign w_vld_o       = wVld_q;
  assign retire_vld_o  = wVld_q;
  assign retire_id_o   = wId_q;
  assign retired_cnt_o = retiredCnt_q;
  assign bubble_cnt_o  = bubbleCnt_q;
  assign flush_cnt_o   = flushCnt_q;
  assign drained_o     = ~(fVld_q | dVld_q | xVld_q | mVld_q | wVld_q);
  assign seq_err_o     = seqErr_q;

endmodule

// File: tb/tb_pipeline_id_tracker.sv
// -----------------------------------------------------------------------------
// tb_pipeline_id_tracker
//
// Drives directed and random stall/flush/halt patterns into two instances of
// pipeline_id_tracker: the default configuration and a tiny one with 2-bit
// counters, which is used to observe saturation. The reference model keeps
// the live instructions as a list of (id, stage) records and moves them by
// the pipeline rules. Expected retires go into a scoreboard queue that an
// independent monitor drains whenever the DUT raises retire_vld.
// -----------------------------------------------------------------------------
module tb_pipeline_id_tracker;

  localparam int ID_DEPTH    = 72;
  localparam int CNT_W       = 32;
  localparam int IW          = $clog2(ID_DEPTH);
  localparam int SMALL_DEPTH = 5;
  localparam int SMALL_CNT_W = 2;
  localparam int SIW         = $clog2(SMALL_DEPTH);
  localparam int SMALL_MAX   = (1 << SMALL_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic pcStall, ifIdStall, ifFlush, idFlush, halt;

  logic [IW-1:0]    fId, dId, xId, mId, wId, retireId;
  logic             fVld, dVld, xVld, mVld, wVld, retireVld, drained, seqErr;
  logic [CNT_W-1:0] retiredCnt, bubbleCnt, flushCnt;

  logic [SIW-1:0]         sFId, sDId, sXId, sMId, sWId, sRetireId;
  logic                   sFVld, sDVld, sXVld, sMVld, sWVld, sRetireVld, sDrained, sSeqErr;
  logic [SMALL_CNT_W-1:0] sRetiredCnt, sBubbleCnt, sFlushCnt;

  always #5 clk = ~clk;

  pipeline_id_tracker #(.ID_DEPTH(ID_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pc_stall_i(pcStall), .if_id_stall_i(ifIdStall),
    .if_flush_i(ifFlush), .id_flush_i(idFlush), .halt_i(halt),
    .f_id_o(fId), .d_id_o(dId), .x_id_o(xId), .m_id_o(mId), .w_id_o(wId),
    .f_vld_o(fVld), .d_vld_o(dVld), .x_vld_o(xVld), .m_vld_o(mVld), .w_vld_o(wVld),
    .retire_vld_o(retireVld), .retire_id_o(retireId),
    .retired_cnt_o(retiredCnt), .bubble_cnt_o(bubbleCnt), .flush_cnt_o(flushCnt),
    .drained_o(drained), .seq_err_o(seqErr)
  );

  pipeline_id_tracker #(.ID_DEPTH(SMALL_DEPTH), .CNT_W(SMALL_CNT_W)) dutSmall (
    .clk_i(clk), .rst_ni(rst_n),
    .pc_stall_i(pcStall), .if_id_stall_i(ifIdStall),
    .if_flush_i(ifFlush), .id_flush_i(idFlush), .halt_i(halt),
    .f_id_o(sFId), .d_id_o(sDId), .x_id_o(sXId), .m_id_o(sMId), .w_id_o(sWId),
    .f_vld_o(sFVld), .d_vld_o(sDVld), .x_vld_o(sXVld), .m_vld_o(sMVld), .w_vld_o(sWVld),
    .retire_vld_o(sRetireVld), .retire_id_o(sRetireId),
    .retired_cnt_o(sRetiredCnt), .bubble_cnt_o(sBubbleCnt), .flush_cnt_o(sFlushCnt),
    .drained_o(sDrained), .seq_err_o(sSeqErr)
  );

  // Posedges seen since the last reset release.
  int cycle;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle <= 0;
    else        cycle <= cycle + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the live instructions behind F, each with its stage
  // (1=ID, 2=EX, 3=MEM, 4=WB), plus the fetch slot and the event tallies.
  typedef struct { int id; int stage; } inst_t;
  typedef struct { int id; int stamp; } exp_t;

  inst_t pipe[$];
  exp_t  expQ[$];
  int    fetchId;
  bit    fetchValid;
  int    expNext;
  bit    seqErrM;
  int    retiredM, bubbleM, flushM;

  task automatic checkVal(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic modelReset();
    pipe.delete();
    fetchId    = 0;
    fetchValid = 1'b1;
    expNext    = 0;
    seqErrM    = 1'b0;
    retiredM   = 0;
    bubbleM    = 0;
    flushM     = 0;
  endtask

  // Advance the model across one rising edge with the given controls.
  task automatic modelStep(input bit stall, input bit ifF, input bit idF, input bit hlt);
    inst_t kept[$];
    inst_t nxt[$];
    inst_t p;
    foreach (pipe[i]) begin
      if (pipe[i].stage == 4) begin
        retiredM++;
        if (pipe[i].id != expNext) seqErrM = 1'b1;
        expNext = (pipe[i].id + 1) % ID_DEPTH;
      end else begin
        kept.push_back(pipe[i]);
      end
    end
    foreach (kept[i]) begin
      p = kept[i];
      if (p.stage == 1) begin
        if (stall) begin
          if (ifF) flushM++;
          else     nxt.push_back(p);
        end else begin
          if (idF) flushM++;
          else begin p.stage = 2; nxt.push_back(p); end
        end
      end else begin
        p.stage = p.stage + 1;
        nxt.push_back(p);
      end
    end
    if (stall) begin
      bubbleM++;
    end else if (fetchValid) begin
      if (ifF) flushM++;
      else     nxt.push_back('{id: fetchId, stage: 1});
      fetchId    = (fetchId + 1) % ID_DEPTH;
      fetchValid = !hlt;
    end
    pipe = nxt;
    foreach (pipe[i]) begin
      if (pipe[i].stage == 4) expQ.push_back('{id: pipe[i].id, stamp: cycle + 1});
    end
  endtask

  function automatic longint satSmall(input int v);
    return (v > SMALL_MAX) ? SMALL_MAX : v;
  endfunction

  // Compare the visible state against the model (state after the last edge).
  task automatic checkOutput();
    bit sv[5];
    int si[5];
    foreach (sv[i]) begin sv[i] = 1'b0; si[i] = 0; end
    foreach (pipe[i]) begin sv[pipe[i].stage] = 1'b1; si[pipe[i].stage] = pipe[i].id; end
    checkVal("f_id", fId, fetchId);
    checkVal("f_vld", fVld, fetchValid);
    checkVal("d_vld", dVld, sv[1]);
    if (sv[1]) checkVal("d_id", dId, si[1]);
    checkVal("x_vld", xVld, sv[2]);
    if (sv[2]) checkVal("x_id", xId, si[2]);
    checkVal("m_vld", mVld, sv[3]);
    if (sv[3]) checkVal("m_id", mId, si[3]);
    checkVal("w_vld", wVld, sv[4]);
    if (sv[4]) checkVal("w_id", wId, si[4]);
    checkVal("retired_cnt", retiredCnt, retiredM);
    checkVal("bubble_cnt", bubbleCnt, bubbleM);
    checkVal("flush_cnt", flushCnt, flushM);
    checkVal("seq_err", seqErr, seqErrM);
    checkVal("drained", drained, (pipe.size() == 0 && !fetchValid));
    checkVal("small_drained", sDrained, (pipe.size() == 0 && !fetchValid));
    checkVal("small_retired_sat", sRetiredCnt, satSmall(retiredM));
    checkVal("small_bubble_sat", sBubbleCnt, satSmall(bubbleM));
    checkVal("small_flush_sat", sFlushCnt, satSmall(flushM));
  endtask

  task automatic applyStimulus(input bit pcS, input bit ifIdS, input bit ifF,
                               input bit idF, input bit hlt);
    pcStall   = pcS;
    ifIdStall = ifIdS;
    ifFlush   = ifF;
    idFlush   = idF;
    halt      = hlt;
    modelStep(pcS | ifIdS, ifF, idF, hlt);
  endtask

  task automatic runCycle(input bit pcS, input bit ifIdS, input bit ifF,
                          input bit idF, input bit hlt);
    @(negedge clk);
    checkOutput();
    applyStimulus(pcS, ifIdS, ifF, idF, hlt);
  endtask

  task automatic runRandom(input int n);
    for (int i = 0; i < n; i++) begin
      runCycle($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 8, 1'b0);
    end
  endtask

  // Retire monitor: every retire must match the head of the scoreboard in ID
  // and in cycle, and no expected retire may be skipped.
  exp_t monE;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (retireVld) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL retire_unexpected: got retire of id %0d, expected none (cycle %0d)",
                   retireId, cycle);
        end else begin
          monE = expQ.pop_front();
          checkVal("retire_id", retireId, monE.id);
          checkVal("retire_cycle", cycle, monE.stamp);
        end
      end else if (expQ.size() != 0 && expQ[0].stamp <= cycle) begin
        monE = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL retire_missing: got no retire, expected id %0d at cycle %0d",
                 monE.id, monE.stamp);
      end
    end
  end

  int waited;

  initial begin
    rst_n     = 1'b0;
    pcStall   = 1'b0;
    ifIdStall = 1'b0;
    ifFlush   = 1'b0;
    idFlush   = 1'b0;
    halt      = 1'b0;
    modelReset();

    // Reset state, then release with idle inputs.
    repeat (2) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    // Idle run: first retire at cycle 4 with ID 0, six retires by cycle 10.
    for (int i = 1; i <= 10; i++) begin
      runCycle(0, 0, 0, 0, 0);
      if (i == 3) checkVal("no_retire_before_4", retireVld, 0);
      if (i == 4) begin
        checkVal("first_retire_vld", retireVld, 1);
        checkVal("first_retire_id", retireId, 0);
      end
      if (i == 10) checkVal("idle_retired_cnt", retiredCnt, 6);
    end

    // Two-cycle IF/ID stall.
    runCycle(0, 1, 0, 0, 0);
    runCycle(0, 1, 0, 0, 0);
    runCycle(0, 0, 0, 0, 0);
    checkVal("stall_bubble_cnt", bubbleCnt, 2);
    repeat (6) runCycle(0, 0, 0, 0, 0);

    // Single if_flush: one ID lost, one sequence error.
    runCycle(0, 0, 1, 0, 0);
    repeat (8) runCycle(0, 0, 0, 0, 0);
    checkVal("flush_one_cnt", flushCnt, 1);
    checkVal("flush_seq_err", seqErr, 1);

    // if_flush and id_flush together kill two instructions.
    runCycle(0, 0, 1, 1, 0);
    runCycle(0, 0, 0, 0, 0);
    checkVal("flush_two_cnt", flushCnt, 3);
    repeat (6) runCycle(0, 0, 0, 0, 0);

    // Long unstalled run covering the 71 -> 0 wrap.
    repeat (80) runCycle(0, 0, 0, 0, 0);

    // Random hazards, then an asynchronous reset in mid-flight.
    runRandom(300);
    @(negedge clk);
    checkOutput();
    rst_n = 1'b0;
    #1;
    checkVal("rst_f_vld", fVld, 1);
    checkVal("rst_d_vld", dVld, 0);
    checkVal("rst_x_vld", xVld, 0);
    checkVal("rst_m_vld", mVld, 0);
    checkVal("rst_w_vld", wVld, 0);
    checkVal("rst_retired_cnt", retiredCnt, 0);
    checkVal("rst_bubble_cnt", bubbleCnt, 0);
    checkVal("rst_flush_cnt", flushCnt, 0);
    checkVal("rst_seq_err", seqErr, 0);
    modelReset();
    expQ.delete();
    pcStall = 1'b0; ifIdStall = 1'b0; ifFlush = 1'b0; idFlush = 1'b0; halt = 1'b0;
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    runRandom(200);

    // Halt with no hazards: the pipeline empties five edges later.
    @(negedge clk);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 1);
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      runCycle(0, 0, 0, 0, 1);
      waited++;
      if (drained) break;
    end
    checkVal("halt_drain_cycles", waited, 5);

    // F stays empty after halt drops.
    repeat (3) runCycle(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput();
    checkVal("scoreboard_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
